// File: rtl/usb_bulk_in_sched.sv
// Bulk-IN packet scheduler: answers each IN token with NAK, a data packet of up to MAX_PKT bytes,
// or a ZLP, then waits for the host handshake. Define SCHED_TIMEOUT_EN for a handshake timeout.
module usb_bulk_in_sched #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned MAX_PKT = 512,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic             s_tlast,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             tok_in_i,
  input  logic             hs_ack_i,
  input  logic             hs_err_i,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic             m_tlast,
  output logic [WIDTH-1:0] m_tdata,
  output logic             nak_o,
  output logic             zlp_o,
  output logic             busy_o,
  output logic             drop_o
);

  localparam int unsigned CntW = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;

  typedef enum logic [2:0] {StIdle, StNak, StZlp, StSend, StWait} state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic            r_zlp_pend;
  logic            r_nak;
  logic            r_zlp;
  logic            r_drop;
  logic            r_busy;

  logic            w_send;
  logic            w_cnt_max;
  logic            w_beat;
  logic            w_tmo;

  assign w_send    = (r_state == StSend);
  assign w_cnt_max = (r_cnt == CntW'(MAX_PKT - 1));

  // Data path is a straight pass-through while sending; gated to zero otherwise.
  assign m_tvalid = w_send & s_tvalid;
  assign m_tdata  = w_send ? s_tdata : '0;
  assign m_tlast  = w_send & s_tvalid & (s_tlast | w_cnt_max);
  assign s_tready = w_send & m_tready;
  assign w_beat   = m_tvalid & m_tready;

  assign nak_o  = r_nak;
  assign zlp_o  = r_zlp;
  assign busy_o = r_busy;
  assign drop_o = r_drop;

`ifdef SCHED_TIMEOUT_EN
  localparam int unsigned TmW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  logic [TmW-1:0] r_tmr;

  // Held at TIMEOUT outside WAIT, so it starts full on WAIT entry.
  always_ff @(posedge clock) begin
    if (reset || (r_state != StWait)) begin
      r_tmr <= TmW'(TIMEOUT);
    end else if (r_tmr != '0) begin
      r_tmr <= r_tmr - 1'b1;
    end
  end

  assign w_tmo = (r_state == StWait) && (r_tmr == '0);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT;
  assign w_tmo            = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_zlp_pend <= 1'b0;
      r_nak      <= 1'b0;
      r_zlp      <= 1'b0;
      r_drop     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_nak  <= 1'b0;
      r_zlp  <= 1'b0;
      r_drop <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (tok_in_i) begin
            r_busy <= 1'b1;
            if (r_zlp_pend) begin
              r_state <= StZlp;
              r_zlp   <= 1'b1;
            end else if (s_tvalid) begin
              r_state <= StSend;
            end else begin
              r_state <= StNak;
              r_nak   <= 1'b1;
            end
          end
        end
        StNak: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        StZlp: begin
          r_zlp_pend <= 1'b0;
          r_state    <= StWait;
        end
        StSend: begin
          if (w_beat) begin
            if (m_tlast) begin
              r_cnt   <= '0;
              r_state <= StWait;
              // A transfer ending exactly on a full packet needs a trailing ZLP.
              if (s_tlast && w_cnt_max) begin
                r_zlp_pend <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        StWait: begin
          if (hs_err_i || w_tmo) begin
            r_drop  <= 1'b1;
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (hs_ack_i) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
